// File: rtl/pc_upstream_arbiter.sv
// Round-robin merge of four payload channels into one coded upstream word stream.
// Defining PC_ARB_NOP_FILL_EN adds an idle-timeout nop word generator.
module pc_upstream_arbiter #(
    parameter int unsigned NCODE        = 8,
    parameter int unsigned NPAYLOAD     = 24,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned CODE0        = 0,
    parameter int unsigned CODE1        = 1,
    parameter int unsigned CODE2        = 2,
    parameter int unsigned CODE3        = 3,
    parameter int unsigned NOP_CODE     = 64,
    parameter int unsigned IDLE_TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in0_v,
    output logic                      in0_a,
    input  logic [NPAYLOAD-1:0]       in0_d,
    input  logic                      in1_v,
    output logic                      in1_a,
    input  logic [NPAYLOAD-1:0]       in1_d,
    input  logic                      in2_v,
    output logic                      in2_a,
    input  logic [NPAYLOAD-1:0]       in2_d,
    input  logic                      in3_v,
    output logic                      in3_a,
    input  logic [NPAYLOAD-1:0]       in3_d,
    output logic                      out_v,
    input  logic                      out_a,
    output logic [NCODE+NPAYLOAD-1:0] out_d,
    output logic [1:0]                grant_idx
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                    state, state_nxt;
    logic [1:0]                last, last_nxt, grant_nxt, rr_sel;
    logic [BW-1:0]             burst_cnt, burst_nxt;
    logic                      out_v_nxt;
    logic [NCODE+NPAYLOAD-1:0] out_d_nxt, load_d;
    logic [3:0]                in_v, in_a;
    logic [NPAYLOAD-1:0]       in_d [4];
    logic [NCODE-1:0]          code [4];
    logic                      src_v, out_free, accept, load, found;

`ifdef PC_ARB_NOP_FILL_EN
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT);
    logic [IW-1:0] idle_cnt, idle_nxt;
`endif

    assign in_v    = {in3_v, in2_v, in1_v, in0_v};
    assign in_d[0] = in0_d;
    assign in_d[1] = in1_d;
    assign in_d[2] = in2_d;
    assign in_d[3] = in3_d;
    assign code[0] = NCODE'(CODE0);
    assign code[1] = NCODE'(CODE1);
    assign code[2] = NCODE'(CODE2);
    assign code[3] = NCODE'(CODE3);
    assign in0_a   = in_a[0];
    assign in1_a   = in_a[1];
    assign in2_a   = in_a[2];
    assign in3_a   = in_a[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= 2'd0;
            last      <= 2'd3;
            burst_cnt <= '0;
            out_v     <= 1'b0;
            out_d     <= '0;
`ifdef PC_ARB_NOP_FILL_EN
            idle_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            out_v     <= out_v_nxt;
            out_d     <= out_d_nxt;
`ifdef PC_ARB_NOP_FILL_EN
            idle_cnt  <= idle_nxt;
`endif
        end
    end

    always_comb begin
        rr_sel    = 2'd0;
        found     = 1'b0;
        state_nxt = state;
        grant_nxt = grant_idx;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        in_a      = '0;

        // Search starts one past the last released source, wrapping mod 4.
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!found && in_v[last + 2'(i)]) begin
                rr_sel = last + 2'(i);
                found  = 1'b1;
            end
        end

        src_v    = in_v[grant_idx];
        out_free = !out_v || out_a;
        accept   = (state == GRANT) && src_v && out_free;
        if (accept && !reset) in_a[grant_idx] = 1'b1;

        case (state)
            IDLE: begin
                if (|in_v) begin
                    state_nxt = GRANT;
                    grant_nxt = rr_sel;
                    burst_nxt = '0;
                end
            end
            GRANT: begin
                if (!src_v) begin
                    state_nxt = IDLE;
                    last_nxt  = grant_idx;
                end else if (accept) begin
                    burst_nxt = burst_cnt + BW'(1);
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = IDLE;
                        last_nxt  = grant_idx;
                    end
                end
            end
        endcase

        load   = accept;
        load_d = {code[grant_idx], in_d[grant_idx]};

`ifdef PC_ARB_NOP_FILL_EN
        idle_nxt = '0;
        if ((state == IDLE) && !(|in_v) && out_free) begin
            if (idle_cnt == IDLE_LAST) begin
                load   = 1'b1;
                load_d = {NCODE'(NOP_CODE), {NPAYLOAD{1'b0}}};
            end else begin
                idle_nxt = idle_cnt + IW'(1);
            end
        end
`endif

        out_v_nxt = out_v;
        out_d_nxt = out_d;
        if (load) begin
            out_v_nxt = 1'b1;
            out_d_nxt = load_d;
        end else if (out_a) begin
            out_v_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_upstream_arbiter.sv
// Self-checking bench for pc_upstream_arbiter: directed latency/stall/reset steps plus
// randomized multi-source traffic checked against a transaction-level grant model.
module tb_pc_upstream_arbiter;

    localparam int unsigned NP = 24;
    localparam int unsigned MB = 16;
    localparam int unsigned TO = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    v, a;
    logic [NP-1:0] d [4];
    logic          out_v, out_a;
    logic [31:0]   out_d;
    logic [1:0]    grant_idx;

    always #5 clk = ~clk;

    pc_upstream_arbiter #(
        .NCODE(8), .NPAYLOAD(NP), .MAX_BURST(MB),
        .CODE0(8'hA0), .CODE1(8'hB1), .CODE2(8'hC2), .CODE3(8'hD3),
        .NOP_CODE(64), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .in0_v(v[0]), .in0_a(a[0]), .in0_d(d[0]),
        .in1_v(v[1]), .in1_a(a[1]), .in1_d(d[1]),
        .in2_v(v[2]), .in2_a(a[2]), .in2_d(d[2]),
        .in3_v(v[3]), .in3_a(a[3]), .in3_d(d[3]),
        .out_v(out_v), .out_a(out_a), .out_d(out_d),
        .grant_idx(grant_idx)
    );

    logic [NP-1:0] srcq [4][$];
    logic [31:0]   expq [$];
    logic [7:0]    code_m [4];
    logic [NP-1:0] w0 [5];
    int            errors = 0;
    int            checks = 0;
    int            acc_cnt [4];
    int            last_t, seen;
    logic          sb_en = 1'b0;
    logic          oa_rand = 1'b0;
    logic          oa_val = 1'b1;
    logic [3:0]    hs;
    logic          ohs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            v[i] = (srcq[i].size() != 0);
            d[i] = v[i] ? srcq[i][0] : '0;
        end
        out_a = oa_rand ? 1'($urandom_range(0, 1)) : oa_val;
    endtask

    // Sample on the falling edge, then apply pops and new inputs just after the rising edge.
    task automatic tick();
        @(negedge clk);
        hs  = v & a;
        ohs = out_v && out_a;
        chk("ack_rule", 32'(($countones(a) <= 1) && ((a & ~v) == 4'd0)), 32'd1);
        if (sb_en && ohs) begin
            chk("word_avail", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                chk("out_word", out_d, expq[0]);
                void'(expq.pop_front());
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                void'(srcq[i].pop_front());
                acc_cnt[i]++;
            end
        end
        drive();
    endtask

    task automatic reset_dut();
        sb_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            srcq[i].delete();
            acc_cnt[i] = 0;
        end
        expq.delete();
        oa_rand = 1'b0;
        oa_val  = 1'b1;
        drive();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_v", 32'(out_v), 32'd0);
        chk("rst_out_d", out_d, 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_ack", 32'(a), 32'd0);
        reset = 1'b0;
    endtask

    // Grant sequence from the arbitration rules: round robin from last+1, burst of up to
    // MB words, a source that runs dry releases early.
    task automatic build_expected();
        int unsigned len [4];
        int unsigned pos [4];
        int unsigned lst, g, n;
        bit          any;
        lst = 3;
        for (int i = 0; i < 4; i++) begin
            len[i] = srcq[i].size();
            pos[i] = 0;
        end
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            g   = 0;
            for (int unsigned k = 1; k <= 4; k++) begin
                if (!any && pos[(lst + k) % 4] < len[(lst + k) % 4]) begin
                    g   = (lst + k) % 4;
                    any = 1'b1;
                end
            end
            if (any) begin
                n = len[g] - pos[g];
                if (n > MB) n = MB;
                for (int unsigned j = 0; j < n; j++)
                    expq.push_back({code_m[g], srcq[g][pos[g] + j]});
                pos[g] += n;
                lst = g;
            end
        end
    endtask

    initial begin
        code_m[0] = 8'hA0; code_m[1] = 8'hB1; code_m[2] = 8'hC2; code_m[3] = 8'hD3;
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;

        // Single source, 5 words, out_a held high: one IDLE cycle then back-to-back words.
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            w0[k] = NP'($urandom());
            srcq[0].push_back(w0[k]);
        end
        drive();
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("lat_out_v", 32'(out_v), 32'((t >= 2) && (t <= 6)));
            if ((t >= 2) && (t <= 6)) chk("lat_out_d", out_d, {code_m[0], w0[t-2]});
        end
        chk("lat_grant", 32'(grant_idx), 32'd0);
        srcq[0].push_back(24'h000011);
        srcq[1].push_back(24'h000022);
        drive();
        tick();
        chk("rr_after_release", 32'(grant_idx), 32'd1);
        repeat (8) tick();

        // Output stall of 10 cycles mid-burst.
        reset_dut();
        for (int k = 0; k < 12; k++) begin
            srcq[1].push_back(NP'($urandom()));
            expq.push_back({code_m[1], srcq[1][k]});
        end
        sb_en = 1'b1;
        drive();
        repeat (4) tick();
        oa_val = 1'b0;
        drive();
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("stall_ack", 32'(a), 32'd0);
            chk("stall_v", 32'(out_v), 32'd1);
            chk("stall_d", out_d, expq[0]);
        end
        oa_val = 1'b1;
        drive();
        for (int t = 0; t < 40 && expq.size() != 0; t++) tick();
        chk("stall_drain", 32'(expq.size()), 32'd0);

        // Reset pulse after the 7th accepted word of a burst.
        reset_dut();
        for (int k = 0; k < 20; k++) srcq[2].push_back(NP'($urandom()));
        drive();
        for (int t = 0; t < 30 && acc_cnt[2] < 7; t++) tick();
        chk("reached_word7", 32'(acc_cnt[2]), 32'd7);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            srcq[0].push_back(NP'($urandom()));
            srcq[1].push_back(NP'($urandom()));
        end
        drive();
        #1;
        chk("rst_mid_ack_hi", 32'(a), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_out_v", 32'(out_v), 32'd0);
        chk("rst_mid_grant", 32'(grant_idx), 32'd0);
        chk("rst_mid_ack", 32'(a), 32'd0);
        tick();
        chk("rst_next_grant", 32'(grant_idx), 32'd0);

        // Randomized traffic on all sources; round 0 is long continuous bursts, no backpressure.
        for (int r = 0; r < 4; r++) begin
            reset_dut();
            for (int i = 0; i < 4; i++) begin
                int unsigned n;
                n = (r == 0) ? 40 : $urandom_range(1, 40);
                for (int unsigned k = 0; k < n; k++) srcq[i].push_back(NP'($urandom()));
            end
            build_expected();
            sb_en   = 1'b1;
            oa_rand = (r != 0);
            drive();
            for (int t = 0; t < 3000 && expq.size() != 0; t++) tick();
            chk("rand_drain", 32'(expq.size()), 32'd0);
            chk("rand_src_empty", 32'(srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()), 32'd0);
            sb_en = 1'b0;
        end

        // All inputs idle with out_a high.
        reset_dut();
        last_t = 0;
        seen   = 0;
`ifdef PC_ARB_NOP_FILL_EN
        for (int t = 1; t <= 4 * (TO + 1) + 2; t++) begin
            tick();
            if (out_v) begin
                chk("nop_word", out_d, {8'd64, 24'd0});
                if (seen > 0) chk("nop_gap", 32'(t - last_t), 32'(TO + 1));
                last_t = t;
                seen++;
            end
        end
        chk("nop_count", 32'(seen), 32'd4);
`else
        for (int t = 0; t < 3 * (TO + 1); t++) begin
            tick();
            chk("idle_out_v", 32'(out_v), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_upstream_arbiter.md
PC_UPSTREAM_ARBITER -- requirements
Module: pc_upstream_arbiter

Interface
REQ-001 Parameter NCODE, default 8: code field width in bits.
REQ-002 Parameter NPAYLOAD, default 24: payload width in bits; the output word is NCODE+NPAYLOAD = 32 bits.
REQ-003 Parameter MAX_BURST, default 16, range 1..256: maximum words accepted per grant.
REQ-004 Parameters CODE0..CODE3, defaults 0,1,2,3: upstream code prepended for each source.
REQ-005 Parameter NOP_CODE, default 64: upstream nop code.
REQ-006 Parameter IDLE_TIMEOUT, default 256: idle cycles before a nop word is emitted (REQ-024 only).
REQ-007 clk  input  1  single clock; all state on posedge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 in0..in3  Channel #(NPAYLOAD) consumer ports  v/a/d  requester channels, in0 = BD upstream traffic.
REQ-010 out  Channel #(NCODE+NPAYLOAD) producer port  v/a/d  merged stream toward the PC upstream FIFO.
REQ-011 grant_idx  output  2  currently or last granted source, for debug and LEDs.

Function
REQ-012 Transfer on any channel occurs when v and a are both high on a clk edge; data SHALL be held while v is high and a is low.
REQ-013 FSM states: IDLE and GRANT.
REQ-014 IDLE: when any in*.v is high, select the first valid source in round-robin order starting at last+1 mod 4, register it into grant_idx, and move to GRANT next cycle; no ack is issued in IDLE.
REQ-015 GRANT: in[grant_idx].a = in[grant_idx].v AND (out register empty OR out.a); all other in*.a SHALL be 0.
REQ-016 Each accepted word SHALL load the output register with {CODEg, in.d} and set out.v the following cycle, giving 1-cycle latency with full throughput of 1 word/cycle under continuous out.a.
REQ-017 Burst counter: cleared on entry to GRANT and incremented per accepted word; at the MAX_BURST-th accept, return to IDLE.
REQ-018 GRANT with in[grant_idx].v low SHALL return to IDLE next cycle (release), even if the counter is 0.
REQ-019 On every GRANT->IDLE transition, last := grant_idx.
REQ-020 Output register: out.v clears on out.a when no new word loads; a simultaneous out.a and load keeps out.v high with the new data.
REQ-021 Starvation bound: with all four sources continuously valid, each source SHALL be granted within 4 grants; grants SHALL repeat in order 0,1,2,3.
REQ-022 A source that drops v mid-burst loses the grant; the word in the output register still drains.

Reset
REQ-023 While reset is high: state=IDLE, out.v=0, out.d=0, all in*.a=0, grant_idx=0, last=3 (so source 0 is first), burst counter=0, idle counter=0; reset mid-burst discards the undelivered output word.

Configuration
REQ-024 Macro PC_ARB_NOP_FILL_EN defined: an idle counter counts cycles in IDLE with no in*.v and an empty output register; at IDLE_TIMEOUT it loads {NOP_CODE, 0} into the output register and clears; a nop is never emitted while any source is valid.
REQ-025 Macro undefined: there is no idle counter and no nop word; out.v stays low whenever no source data is pending.

Verification
REQ-026 in0 valid with 5 words, out.a=1 -> grant after 1 IDLE cycle; out shows {CODE0,d0..d4} on 5 consecutive cycles; then IDLE, last=0.
REQ-027 All sources continuously valid, MAX_BURST=16 -> bursts of 16 words in source order 0,1,2,3,0; no source gets two bursts while another waits.
REQ-028 out.a held low for 10 cycles mid-burst -> in.a=0, out.d stable, no word lost or duplicated; the burst resumes when out.a returns.
REQ-029 reset pulsed for 1 cycle during a burst at word 7 -> next cycle out.v=0, state IDLE, grant_idx=0; the next grant goes to the lowest valid source starting at 0.
REQ-030 PC_ARB_NOP_FILL_EN defined, all inputs idle -> exactly one {64,0} word every IDLE_TIMEOUT+1 cycles. Undefined -> out.v stays 0.
